// File: rtl/count_seq_monitor.sv
// Sequence monitor for a WIDTH-bit up-counter: tracks the expected next value, locks after LOCK_N good steps.
// Latency 1 cycle (all outputs registered); no backpressure, a sample is consumed on every clock edge.
module count_seq_monitor #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_clr,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] wrap_count
);

    localparam int MW = $clog2(LOCK_N + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_N);

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_nxt;
    logic             clr_d;
    logic             clr_d_nxt;
    logic [MW-1:0]    match_cnt;
    logic [MW-1:0]    match_cnt_nxt;
    logic [WIDTH-1:0] cur_exp;
    logic [WIDTH-1:0] expected_nxt;
    logic             err_pulse_nxt;
    logic             wrap_pulse_nxt;
    logic [CNT_W-1:0] err_count_nxt;
    logic [CNT_W-1:0] wrap_count_nxt;
    logic             sample_ok;
    logic             wrap_hit;

    // A registered clear forces the next sample to 0, so a held clear keeps expecting 0.
    assign cur_exp   = clr_d ? '0 : prev + WIDTH'(1);
    assign sample_ok = (count_in == cur_exp);
    assign wrap_hit  = sample_ok && !clr_d && (&prev) && (count_in == '0);

    always_comb begin
        state_nxt      = state;
        match_cnt_nxt  = match_cnt;
        err_pulse_nxt  = 1'b0;
        wrap_pulse_nxt = 1'b0;
        err_count_nxt  = err_count;
        wrap_count_nxt = wrap_count;
        prev_nxt       = count_in;
        clr_d_nxt      = count_clr;

        case (state)
            UNSYNC: begin
                match_cnt_nxt = '0;
                state_nxt     = SYNC;
            end
            SYNC: begin
                if (sample_ok) begin
                    match_cnt_nxt = match_cnt + MW'(1);
                    if (match_cnt_nxt == LOCK_V) begin
                        state_nxt = LOCKED;
                    end
                end else begin
                    match_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (!sample_ok) begin
                    err_pulse_nxt = 1'b1;
                    if (!(&err_count)) begin
                        err_count_nxt = err_count + CNT_W'(1);
                    end
                    match_cnt_nxt = '0;
                    state_nxt     = SYNC;
                end else if (wrap_hit) begin
                    wrap_pulse_nxt = 1'b1;
                    wrap_count_nxt = wrap_count + CNT_W'(1);
                end
            end
            default: begin
                match_cnt_nxt = '0;
                state_nxt     = UNSYNC;
            end
        endcase

        expected_nxt = clr_d_nxt ? '0 : prev_nxt + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= UNSYNC;
            prev       <= '0;
            clr_d      <= 1'b0;
            match_cnt  <= '0;
            locked     <= 1'b0;
            expected   <= '0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            wrap_pulse <= 1'b0;
            wrap_count <= '0;
        end else begin
            state      <= state_nxt;
            prev       <= prev_nxt;
            clr_d      <= clr_d_nxt;
            match_cnt  <= match_cnt_nxt;
            locked     <= (state_nxt == LOCKED);
            expected   <= expected_nxt;
            err_pulse  <= err_pulse_nxt;
            err_count  <= err_count_nxt;
            wrap_pulse <= wrap_pulse_nxt;
            wrap_count <= wrap_count_nxt;
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed scenarios plus a randomized counter stream against a behavioural model.
module tb_count_seq_monitor;

    localparam int LN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] count_in = '0;
    logic       count_clr = 1'b0;

    logic       locked;
    logic [3:0] expected;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       wrap_pulse;
    logic [7:0] wrap_count;

    logic       locked2;
    logic [3:0] expected2;
    logic       err_pulse2;
    logic [1:0] err_count2;
    logic       wrap_pulse2;
    logic [1:0] wrap_count2;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int m_prev = 0, m_clr = 0, m_run = 0, m_unsync = 1, m_locked = 0;
    int m_exp = 0, m_ep = 0, m_wp = 0, m_ec = 0, m_wc = 0, m_ec2 = 0;

    count_seq_monitor #(.WIDTH(4), .LOCK_N(LN), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .count_clr(count_clr),
        .locked(locked), .expected(expected), .err_pulse(err_pulse),
        .err_count(err_count), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
    );

    count_seq_monitor #(.WIDTH(4), .LOCK_N(LN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_clr(count_clr),
        .locked(locked2), .expected(expected2), .err_pulse(err_pulse2),
        .err_count(err_count2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2)
    );

    always #5 clk = ~clk;

    // Drive one sample, let the edge happen, advance the model, then settle past the edge.
    task automatic step(input int cin, input int clr, input int rst);
        int need;
        @(negedge clk);
        count_in  = 4'(cin);
        count_clr = clr[0];
        reset     = rst[0];
        @(posedge clk);
        m_ep = 0;
        m_wp = 0;
        if (rst == 0) begin
            m_prev = 0; m_clr = 0; m_run = 0; m_unsync = 1; m_locked = 0;
            m_ec = 0; m_wc = 0; m_ec2 = 0;
        end else if (m_unsync != 0) begin
            m_unsync = 0; m_run = 0; m_prev = cin; m_clr = clr;
        end else begin
            need = (m_clr != 0) ? 0 : (m_prev + 1) % 16;
            if (m_locked != 0) begin
                if (cin != need) begin
                    m_ep = 1; m_locked = 0; m_run = 0;
                    if (m_ec < 255) m_ec++;
                    if (m_ec2 < 3) m_ec2++;
                end else if (m_clr == 0 && m_prev == 15 && cin == 0) begin
                    m_wp = 1;
                    m_wc = (m_wc + 1) % 256;
                end
            end else if (cin == need) begin
                m_run++;
                if (m_run == LN) m_locked = 1;
            end else begin
                m_run = 0;
            end
            m_prev = cin;
            m_clr  = clr;
        end
        m_exp = (rst == 0 || m_clr != 0) ? 0 : (m_prev + 1) % 16;
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0);
        step(5, 1, 0);
        checks++;
        if ({locked, expected, err_pulse, err_count, wrap_pulse, wrap_count} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs got lk=%0b exp=%0d ep=%0b ec=%0d wp=%0b wc=%0d want all 0",
                     locked, expected, err_pulse, err_count, wrap_pulse, wrap_count);
        end
        checks++;
        if ({locked2, err_count2} !== 3'd0) begin
            failures++;
            $display("FAIL reset_dut2 got lk=%0b ec=%0d want 0", locked2, err_count2);
        end
    endtask

    task automatic test_lock();
        int seq[4]   = '{3, 4, 5, 6};
        int w_lk[4]  = '{0, 0, 1, 1};
        int w_exp[4] = '{4, 5, 6, 7};
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 0, 1);
            checks++;
            if (locked !== w_lk[i][0] || expected !== 4'(w_exp[i]) || err_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
                failures++;
                $display("FAIL lock_seq i=%0d got lk=%0b exp=%0d ep=%0b wp=%0b want lk=%0d exp=%0d no pulses",
                         i, locked, expected, err_pulse, wrap_pulse, w_lk[i], w_exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int seq[4]  = '{14, 15, 0, 1};
        int w_wp[4] = '{0, 0, 1, 0};
        int w_wc[4] = '{0, 0, 1, 1};
        for (int v = 7; v <= 13; v++) step(v, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(seq[i], 0, 1);
            checks++;
            if (wrap_pulse !== w_wp[i][0] || wrap_count !== 8'(w_wc[i]) || locked !== 1'b1 || err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL wrap i=%0d got wp=%0b wc=%0d lk=%0b ep=%0b want wp=%0d wc=%0d lk=1 ep=0",
                         i, wrap_pulse, wrap_count, locked, err_pulse, w_wp[i], w_wc[i]);
            end
        end
    endtask

    task automatic test_clear();
        int seq[4]   = '{7, 0, 0, 1};
        int clr[4]   = '{1, 1, 0, 0};
        int w_exp[4] = '{0, 0, 1, 2};
        for (int v = 2; v <= 6; v++) step(v, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(seq[i], clr[i], 1);
            checks++;
            if (err_pulse !== 1'b0 || wrap_pulse !== 1'b0 || locked !== 1'b1 ||
                wrap_count !== 8'd1 || expected !== 4'(w_exp[i])) begin
                failures++;
                $display("FAIL clear i=%0d got ep=%0b wp=%0b lk=%0b wc=%0d exp=%0d want 0 0 1 1 %0d",
                         i, err_pulse, wrap_pulse, locked, wrap_count, expected, w_exp[i]);
            end
        end
    endtask

    task automatic test_error();
        for (int v = 2; v <= 9; v++) step(v, 0, 1);
        step(12, 0, 1);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || expected !== 4'd13) begin
            failures++;
            $display("FAIL error_inject got ep=%0b ec=%0d lk=%0b exp=%0d want 1 1 0 13",
                     err_pulse, err_count, locked, expected);
        end
        step(13, 0, 1);
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'd1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL error_sync1 got ep=%0b ec=%0d lk=%0b want 0 1 0", err_pulse, err_count, locked);
        end
        step(14, 0, 1);
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL error_relock got ep=%0b ec=%0d lk=%0b want 0 1 1", err_pulse, err_count, locked);
        end
    endtask

    task automatic test_reset_mid();
        int w_lk[3] = '{0, 0, 1};
        step(3, 0, 1);
        step(4, 0, 1);
        step(5, 0, 1);
        checks++;
        if (err_count !== 8'd2 || wrap_count !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got ec=%0d wc=%0d lk=%0b want 2 1 1", err_count, wrap_count, locked);
        end
        step(6, 0, 0);
        checks++;
        if ({locked, expected, err_pulse, err_count, wrap_pulse, wrap_count} !== 23'd0) begin
            failures++;
            $display("FAIL mid_reset got lk=%0b exp=%0d ep=%0b ec=%0d wp=%0b wc=%0d want all 0",
                     locked, expected, err_pulse, err_count, wrap_pulse, wrap_count);
        end
        for (int i = 0; i < 3; i++) begin
            step(7 + i, 0, 1);
            checks++;
            if (locked !== w_lk[i][0] || err_count !== 8'd0 || err_pulse !== 1'b0) begin
                failures++;
                $display("FAIL relock i=%0d got lk=%0b ec=%0d ep=%0b want lk=%0d ec=0 ep=0",
                         i, locked, err_count, err_pulse, w_lk[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int w_ec2[5] = '{1, 2, 3, 3, 3};
        int cur = 9;
        int bad;
        for (int i = 0; i < 5; i++) begin
            bad = (cur + 5) % 16;
            step(bad, 0, 1);
            checks++;
            if (err_pulse2 !== 1'b1 || err_count2 !== 2'(w_ec2[i]) || err_pulse !== 1'b1) begin
                failures++;
                $display("FAIL saturate i=%0d got ep2=%0b ec2=%0d ep=%0b want ep2=1 ec2=%0d ep=1",
                         i, err_pulse2, err_count2, err_pulse, w_ec2[i]);
            end
            step((bad + 1) % 16, 0, 1);
            step((bad + 2) % 16, 0, 1);
            cur = (bad + 2) % 16;
            checks++;
            if (locked2 !== 1'b1 || err_pulse2 !== 1'b0) begin
                failures++;
                $display("FAIL saturate_relock i=%0d got lk2=%0b ep2=%0b want 1 0", i, locked2, err_pulse2);
            end
        end
    endtask

    task automatic test_random();
        int cur = 0;
        int cin, clr, rst;
        logic [26:0] got, want;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0) ? 0 : 1;
            clr = ($urandom_range(0, 99) < 8) ? 1 : 0;
            cin = ($urandom_range(0, 99) < 4) ? int'($urandom_range(0, 15)) : cur;
            step(cin, clr, rst);
            cur = (clr != 0) ? 0 : (cur + 1) % 16;
            got  = {locked, expected, err_pulse, err_count, wrap_pulse, wrap_count, err_count2, locked2};
            want = {1'(m_locked), 4'(m_exp), 1'(m_ep), 8'(m_ec), 1'(m_wp), 8'(m_wc), 2'(m_ec2), 1'(m_locked)};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random n=%0d cin=%0d clr=%0d rst=%0d got=%h want=%h", n, cin, clr, rst, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_clear();
        test_error();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
